// File: rtl/muldiv_issue.sv
// muldiv_issue: issue/writeback controller in front of mul_div. Captures M-extension ops,
// pulses start, stalls decode until the result is acknowledged and drains on flush.

typedef enum logic [3:0] {
   AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra, AluSlt, AluSltu,
   AluMul, AluDiv, AluDivu, AluRem, AluRemu
} alu_op_type;

module muldiv_issue #(
   parameter int unsigned XLEN_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_id_valid,
   input  alu_op_type            i_id_op,
   input  logic [XLEN_WIDTH-1:0] i_id_rs1_data,
   input  logic [XLEN_WIDTH-1:0] i_id_rs2_data,
   input  logic [4:0]            i_id_rd,
   input  logic                  i_flush,
   output logic                  o_md_start,
   output alu_op_type            o_md_operation,
   output logic [XLEN_WIDTH-1:0] o_md_operand1,
   output logic [XLEN_WIDTH-1:0] o_md_operand2,
   input  logic [XLEN_WIDTH-1:0] i_md_result,
   input  logic                  i_md_ready,
   output logic                  o_stall,
   output logic                  o_wb_valid,
   output logic [4:0]            o_wb_rd,
   output logic [XLEN_WIDTH-1:0] o_wb_data,
   output logic                  o_wb_err,
   input  logic                  i_wb_ack,
   output logic [31:0]           o_busy_cycles
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StDrain} state_e;

   state_e                r_state;
   state_e                w_state_next;
   logic                  w_is_md;
   logic                  w_accept;
   logic                  w_timeout;
   logic [CNT_W-1:0]      r_wait_cnt;
   alu_op_type            r_md_op;
   logic [XLEN_WIDTH-1:0] r_md_op1;
   logic [XLEN_WIDTH-1:0] r_md_op2;
   logic [4:0]            r_wb_rd;
   logic [XLEN_WIDTH-1:0] r_wb_data;
   logic                  r_wb_err;
   logic [31:0]           r_busy;

   assign w_is_md   = i_id_op inside {AluMul, AluDiv, AluDivu, AluRem, AluRemu};
   // Gated by reset so every output reads 0 while reset is held.
   assign w_accept  = !i_reset && (r_state == StIdle) && i_id_valid && w_is_md && !i_flush;
   assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_next = StIssue;
         StIssue: w_state_next = i_flush ? StDrain : StWait;
         StWait: begin
            // A ready seen together with flush needs no drain: mul_div is already idle.
            if (i_flush) begin
               w_state_next = i_md_ready ? StIdle : StDrain;
            end else if (i_md_ready || w_timeout) begin
               w_state_next = StDone;
            end
         end
         StDone:  if (i_flush || i_wb_ack) w_state_next = StIdle;
         StDrain: if (i_md_ready || w_timeout) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      o_md_start = (r_state == StIssue);
      o_wb_valid = (r_state == StDone);
      o_stall    = !i_flush && (w_accept || (r_state == StIssue) || (r_state == StWait) ||
                                ((r_state == StDone) && !i_wb_ack));
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_md_op    <= AluAdd;
         r_md_op1   <= '0;
         r_md_op2   <= '0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
         r_wb_err   <= 1'b0;
         r_wait_cnt <= '0;
         r_busy     <= '0;
      end else begin
         if (w_accept) begin
            r_md_op  <= i_id_op;
            r_md_op1 <= i_id_rs1_data;
            r_md_op2 <= i_id_rs2_data;
            r_wb_rd  <= i_id_rd;
         end
         if ((r_state == StWait) && !i_flush) begin
            if (i_md_ready) begin
               r_wb_data <= i_md_result;
               r_wb_err  <= 1'b0;
            end else if (w_timeout) begin
               r_wb_data <= '0;
               r_wb_err  <= 1'b1;
            end
         end
         // The timeout budget spans WAIT and any DRAIN that follows it.
         if (w_accept) begin
            r_wait_cnt <= '0;
         end else if (((r_state == StWait) || (r_state == StDrain)) && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         if (((r_state == StIssue) || (r_state == StWait) || (r_state == StDrain)) &&
             (r_busy != 32'hFFFF_FFFF)) begin
            r_busy <= r_busy + 32'd1;
         end
      end
   end

   assign o_md_operation = r_md_op;
   assign o_md_operand1  = r_md_op1;
   assign o_md_operand2  = r_md_op2;
   assign o_wb_rd        = r_wb_rd;
   assign o_wb_data      = r_wb_data;
   assign o_wb_err       = r_wb_err;
   assign o_busy_cycles  = r_busy;

endmodule

// File: tb/tb_muldiv_issue.sv
// tb_muldiv_issue: directed bench; stimulus pushes expected issue and writeback records,
// a negedge monitor pops and compares them whenever the DUT presents them.
`timescale 1ns/1ps
module tb_muldiv_issue;
   localparam int unsigned XLEN = 32;
   localparam int unsigned TMO  = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        id_valid;
   alu_op_type  id_op;
   logic [31:0] rs1, rs2;
   logic [4:0]  rd;
   logic        flush;
   logic        md_start;
   alu_op_type  md_operation;
   logic [31:0] md_op1, md_op2, md_result;
   logic        md_ready, stall, wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_err, wb_ack;
   logic [31:0] busy;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct packed {logic [3:0] op; logic [31:0] a; logic [31:0] b;} iss_t;
   typedef struct packed {logic [4:0] rd; logic [31:0] data; logic err;} wb_t;
   iss_t q_iss[$];
   wb_t  q_wb[$];

   always #5 clk = ~clk;

   muldiv_issue #(.XLEN_WIDTH(XLEN), .TIMEOUT_CYCLES(TMO)) u_dut (
      .i_clk(clk), .i_reset(reset), .i_id_valid(id_valid), .i_id_op(id_op),
      .i_id_rs1_data(rs1), .i_id_rs2_data(rs2), .i_id_rd(rd), .i_flush(flush),
      .o_md_start(md_start), .o_md_operation(md_operation), .o_md_operand1(md_op1),
      .o_md_operand2(md_op2), .i_md_result(md_result), .i_md_ready(md_ready),
      .o_stall(stall), .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
      .o_wb_err(wb_err), .i_wb_ack(wb_ack), .o_busy_cycles(busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
   endtask

   task automatic push_iss(input alu_op_type op, input logic [31:0] a, input logic [31:0] b);
      iss_t e;
      e.op = op; e.a = a; e.b = b;
      q_iss.push_back(e);
   endtask

   task automatic push_wb(input logic [4:0] r, input logic [31:0] d, input logic err);
      wb_t e;
      e.rd = r; e.data = d; e.err = err;
      q_wb.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      iss_t ei;
      wb_t  ew;
      if (!reset) begin
         if (md_start) begin
            check("start_pending", 64'(q_iss.size() != 0), 64'd1);
            if (q_iss.size() != 0) begin
               ei = q_iss.pop_front();
               check("md_operation", 64'(md_operation), 64'(ei.op));
               check("md_operand1", 64'(md_op1), 64'(ei.a));
               check("md_operand2", 64'(md_op2), 64'(ei.b));
            end
         end
         if (wb_valid && wb_ack) begin
            check("wb_pending", 64'(q_wb.size() != 0), 64'd1);
            if (q_wb.size() != 0) begin
               ew = q_wb.pop_front();
               check("wb_rd", 64'(wb_rd), 64'(ew.rd));
               check("wb_data", 64'(wb_data), 64'(ew.data));
               check("wb_err", 64'(wb_err), 64'(ew.err));
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      check({tag, "_ctrl"}, 64'({md_start, stall, wb_valid, wb_err}), 64'd0);
      check({tag, "_wb"}, 64'({wb_rd, wb_data}), 64'd0);
      check({tag, "_md"}, 64'({md_operation, md_op1, md_op2}), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; id_valid = 1'b0; flush = 1'b0; md_ready = 1'b0; wb_ack = 1'b0;
      @(negedge clk);
      check_zero("rst");
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // One full operation: accept, ISSUE, WAIT (ready after rdy_dly cycles or timeout), DONE.
   task automatic run_op(input alu_op_type op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] res, input int rdy_dly,
                         input int ack_dly, input bit tmo);
      int          n_wait;
      logic [31:0] want;
      n_wait = tmo ? TMO : ((rdy_dly == 0) ? 1 : rdy_dly);
      want   = tmo ? 32'd0 : res;
      @(posedge clk); #1;
      flush = 1'b0; md_ready = 1'b0;
      id_valid = 1'b1; id_op = op; rs1 = a; rs2 = b; rd = r;
      push_iss(op, a, b);
      push_wb(r, want, tmo);
      @(negedge clk);
      check("accept_stall", 64'(stall), 64'd1);
      check("accept_no_start", 64'(md_start), 64'd0);
      @(posedge clk); #1;
      id_valid = 1'b0;
      if (!tmo && rdy_dly == 0) begin
         md_ready = 1'b1; md_result = res;
      end
      @(negedge clk);
      check("issue_start", 64'(md_start), 64'd1);
      check("issue_stall", 64'(stall), 64'd1);
      check("issue_no_wb", 64'(wb_valid), 64'd0);
      for (int k = 1; k <= n_wait; k++) begin
         @(posedge clk); #1;
         if (!tmo && k == rdy_dly) begin
            md_ready = 1'b1; md_result = res;
         end
         @(negedge clk);
         check("wait_no_start", 64'(md_start), 64'd0);
         check("wait_stall", 64'(stall), 64'd1);
         check("wait_no_wb", 64'(wb_valid), 64'd0);
      end
      @(posedge clk); #1;
      md_ready = 1'b0; md_result = 32'hDEAD_BEEF; wb_ack = (ack_dly == 0);
      for (int k = 0; k < ack_dly; k++) begin
         @(negedge clk);
         check("done_valid", 64'(wb_valid), 64'd1);
         check("done_stall", 64'(stall), 64'd1);
         check("done_hold", 64'(wb_data), 64'(want));
         @(posedge clk); #1;
         if (k == ack_dly - 1) wb_ack = 1'b1;
      end
      @(negedge clk);
      check("ack_valid", 64'(wb_valid), 64'd1);
      check("ack_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      wb_ack = 1'b0;
      @(negedge clk);
      check("idle_after_ack", 64'({wb_valid, stall, md_start}), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: bench did not finish, n_pass=%0d", n_pass);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; id_valid = 1'b0; id_op = AluAdd; rs1 = '0; rs2 = '0; rd = '0;
      flush = 1'b0; md_result = '0; md_ready = 1'b0; wb_ack = 1'b0;
      do_reset();

      run_op(AluMul, 32'd7, 32'd6, 5'd5, 32'd42, 4, 1, 1'b0);
      run_op(AluDivu, 32'd100, 32'd7, 5'd9, 32'd14, 2, 3, 1'b0);

      // DIV flushed in WAIT, MUL presented while mul_div drains
      do_reset();
      @(posedge clk); #1;
      id_valid = 1'b1; id_op = AluDiv; rs1 = 32'hFFFF_FFEC; rs2 = 32'd3; rd = 5'd3;
      push_iss(AluDiv, 32'hFFFF_FFEC, 32'd3);
      @(negedge clk);
      check("div_accept_stall", 64'(stall), 64'd1);
      @(posedge clk); #1;
      id_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      check("flush_stall", 64'(stall), 64'd0);
      check("flush_no_wb", 64'(wb_valid), 64'd0);
      for (int k = 1; k <= 5; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            flush = 1'b0;
            id_valid = 1'b1; id_op = AluMul; rs1 = 32'd3; rs2 = 32'd5; rd = 5'd4;
         end
         if (k == 5) begin
            md_ready = 1'b1; md_result = 32'hFFFF_FFFA;
         end
         @(negedge clk);
         check("drain_no_start", 64'(md_start), 64'd0);
         check("drain_no_wb", 64'(wb_valid), 64'd0);
      end
      run_op(AluMul, 32'd3, 32'd5, 5'd4, 32'd15, 1, 0, 1'b0);
      // DIV: ISSUE + WAIT + 5 DRAIN; MUL: ISSUE + WAIT
      check("busy_with_drain", 64'(busy), 64'd9);

      run_op(AluRem, 32'hFFFF_FFEF, 32'd5, 5'd7, 32'hFFFF_FFFE, 0, 0, 1'b0);

      // flush and ready in the same WAIT cycle: straight back to IDLE
      @(posedge clk); #1;
      id_valid = 1'b1; id_op = AluDivu; rs1 = 32'd50; rs2 = 32'd0; rd = 5'd6;
      push_iss(AluDivu, 32'd50, 32'd0);
      @(posedge clk); #1;
      id_valid = 1'b0;
      @(posedge clk); #1;
      flush = 1'b1; md_ready = 1'b1; md_result = 32'hFFFF_FFFF;
      @(negedge clk);
      check("flush_rdy_stall", 64'(stall), 64'd0);
      run_op(AluRemu, 32'd17, 32'd5, 5'd1, 32'd2, 1, 0, 1'b0);

      run_op(AluMul, 32'd3, 32'd3, 5'd2, 32'd9, 0, 1, 1'b1);

      // non-M op is ignored
      @(posedge clk); #1;
      id_valid = 1'b1; id_op = AluAdd; rs1 = 32'd1; rs2 = 32'd2; rd = 5'd8;
      @(negedge clk);
      check("add_no_stall", 64'(stall), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("add_no_start", 64'({md_start, stall}), 64'd0);

      // reset in the middle of WAIT
      @(posedge clk); #1;
      id_op = AluDivu; rs1 = 32'd9; rs2 = 32'd3; rd = 5'd10;
      push_iss(AluDivu, 32'd9, 32'd3);
      @(posedge clk); #1;
      id_valid = 1'b0;
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      check_zero("midwait_rst");
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_idle", 64'({md_start, stall, wb_valid}), 64'd0);

      check("iss_queue_empty", 64'(q_iss.size()), 64'd0);
      check("wb_queue_empty", 64'(q_wb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/muldiv_issue.md
# muldiv_issue

Issue and writeback controller in the execute stage, directly upstream of `mul_div`. It captures M-extension operations (MUL, DIV, DIVU, REM, REMU) from decode, registers the operands, and pulses `start` to `mul_div`. It stalls the pipeline until `mul_div` signals `ready`, then holds the result on a writeback port until it is acknowledged. It also handles flushes by draining any operation `mul_div` is still executing, and counts busy cycles for performance monitoring.

## Interface
- `XLEN_WIDTH`, default from `common`: datapath width.
- `TIMEOUT_CYCLES`, default 64: maximum number of WAIT cycles before the operation is aborted with an error.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  decode is presenting an instruction.
- `id_op`  in  `alu_op_type`  operation of that instruction.
- `id_rs1_data`  in  XLEN_WIDTH  first operand.
- `id_rs2_data`  in  XLEN_WIDTH  second operand.
- `id_rd`  in  5  destination register.
- `flush`  in  1  kills the in-flight operation.
- `md_start`  out  1  one-cycle start pulse to `mul_div`.
- `md_operation`  out  `alu_op_type`  registered operation.
- `md_operand1`  out  XLEN_WIDTH  registered first operand.
- `md_operand2`  out  XLEN_WIDTH  registered second operand.
- `md_result`  in  XLEN_WIDTH  result from `mul_div`.
- `md_ready`  in  1  result valid from `mul_div`, treated as a level.
- `stall`  out  1  holds decode and execute; the instruction stays presented on `id_*` while high.
- `wb_valid`  out  1  a result is held for writeback.
- `wb_rd`  out  5  destination register of the held result.
- `wb_data`  out  XLEN_WIDTH  held result.
- `wb_err`  out  1  the held result came from a timeout.
- `wb_ack`  in  1  writeback has consumed the result.
- `busy_cycles`  out  32  saturating count of cycles spent in ISSUE, WAIT or DRAIN.

## Operation
- `is_md` is true when `id_op` is one of ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
- `accept` = `state==IDLE && id_valid && is_md && !flush`.
- States and transitions:
  - IDLE: on `accept`, latch op, operands and rd into `md_*`/`wb_rd`; go to ISSUE.
  - ISSUE: `md_start=1` for exactly this cycle; `md_ready` is ignored; go to WAIT.
  - WAIT: on `md_ready`, capture `wb_data=md_result`, `wb_err=0`, go to DONE.
    - If the wait counter reaches TIMEOUT_CYCLES first, set `wb_data=0`, `wb_err=1`, go to DONE.
    - The counter clears on entry to ISSUE.
  - DONE: `wb_valid=1`; on `wb_ack`, go to IDLE.
  - DRAIN: wait for `md_ready` and discard the result, or time out; go to IDLE.
- `stall` = `accept | ISSUE | WAIT | (DONE & !wb_ack)`, forced to 0 when `flush=1`.
- `stall` drops combinationally in the `wb_ack` cycle, so the pipeline advances and the same instruction is never re-accepted.
- Flush behaviour:
  - Flush in ISSUE or WAIT: go to DRAIN; `wb_valid` stays 0.
  - Flush in DONE: go to IDLE; the held result is dropped.
  - Flush in IDLE or DRAIN: no state change; no accept occurs.
- `md_start` is never asserted in DRAIN or IDLE, so `mul_div` never receives two overlapping starts.
- `md_*` operands and op hold their values from accept until the next accept.
- `busy_cycles` increments in ISSUE, WAIT and DRAIN and saturates at 0xFFFF_FFFF.

## Timing
- Reset: state IDLE; all outputs 0; `busy_cycles` 0; counters 0.
- Reset mid-operation returns to IDLE with no DRAIN; the `mul_div` reset is expected to clear it as well.
- Latency:
  - Cycle 0: accept.
  - Cycle 1: `md_start`.
  - First `md_ready` at cycle ≥2: `wb_valid` asserted the following cycle.
- Minimum accept-to-`wb_valid` latency is 3 cycles.
- With `wb_ack` already high in DONE, the next accept can occur one cycle after DONE.
- `md_ready` high during ISSUE (stale level from the previous operation) must not complete the operation.
- `flush` and `md_ready` in the same WAIT cycle: flush wins; the result is discarded and the state goes to IDLE directly, because the ready has already been seen.
- `flush` and `wb_ack` in the same DONE cycle: go to IDLE; both resolve to the same result.

## Test plan
- MUL 7×6, ready 4 cycles after start → `md_start` high exactly 1 cycle; `wb_valid` with `wb_data=42`, `wb_rd` as issued; `stall` high from accept until the `wb_ack` cycle.
- DIVU 100/7 with `wb_ack` held low 3 cycles → `wb_data=14` stable and `stall` high for all 3 cycles; IDLE one cycle after ack.
- Flush in WAIT of DIV, `md_ready` 5 cycles later; next MUL presented → no `wb_valid`, MUL `md_start` only after the drained ready; `busy_cycles` includes the DRAIN cycles.
- `md_ready` held high through ISSUE → no completion in ISSUE; completion in the first WAIT cycle.
- `md_ready` never asserted with TIMEOUT_CYCLES=64 → `wb_valid=1`, `wb_err=1`, `wb_data=0` after 64 WAIT cycles.
- Non-M op (ALU_ADD) with `id_valid` → no accept, `stall=0`, `md_start=0`; assert `reset` mid-WAIT → all outputs 0 immediately.
